// File: rtl/merge2_leaf_pkg.sv
// Shared NoC definitions for the leaf merge: packet geometry, S encodings, FSM states.
package merge2_leaf_pkg;

  localparam int unsigned PKT_W   = 9;
  localparam int unsigned ADDR_HI = 8;
  localparam int unsigned ADDR_LO = 5;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND_S,
    SEND_D
  } state_e;

endpackage

// File: rtl/arb2_rr.sv
// Two-input grant. With ARB_RR_EN the tie-break toggles to the loser after each
// delivered packet; otherwise INIT_PRIO wins every tie.
module arb2_rr
  import merge2_leaf_pkg::*;
#(
  parameter bit INIT_PRIO = 1'b0
) (
`ifdef ARB_RR_EN
  input  logic CLK,
  input  logic RESET,
  input  logic upd,
  input  logic upd_src,
`endif
  input  logic v0,
  input  logic v1,
  output logic gnt,
  output logic gnt_any
);

  logic prio;

`ifdef ARB_RR_EN
  always_ff @(posedge CLK) begin
    if (RESET)    prio <= INIT_PRIO;
    else if (upd) prio <= ~upd_src;
  end
`else
  assign prio = INIT_PRIO;
`endif

  always_comb begin
    gnt = SEL_IN0;
    if (v0 && v1) gnt = prio;
    else if (v1)  gnt = SEL_IN1;
  end

  assign gnt_any = v0 | v1;

endmodule

// File: rtl/merge2_leaf.sv
// Leaf merge: arbitrates In0/In1 into one upstream channel, sending an S source
// token before each packet. Build macro ARB_RR_EN selects round-robin arbitration.
module merge2_leaf
  import merge2_leaf_pkg::*;
#(
  parameter int unsigned W         = PKT_W,
  parameter bit          INIT_PRIO = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] In0_data,
  input  logic         In0_valid,
  output logic         In0_ready,
  input  logic [W-1:0] In1_data,
  input  logic         In1_valid,
  output logic         In1_ready,
  output logic         S_data,
  output logic         S_valid,
  input  logic         S_ready,
  output logic [W-1:0] Out_data,
  output logic         Out_valid,
  input  logic         Out_ready
);

  state_e         state_q, state_d;
  logic [W-1:0]   data_q;
  logic           src_q;
  logic           gnt, gnt_any, accept;

`ifdef ARB_RR_EN
  logic out_done;
  assign out_done = Out_valid & Out_ready;
`endif

  arb2_rr #(.INIT_PRIO(INIT_PRIO)) u_arb (
`ifdef ARB_RR_EN
    .CLK     (CLK),
    .RESET   (RESET),
    .upd     (out_done),
    .upd_src (src_q),
`endif
    .v0      (In0_valid),
    .v1      (In1_valid),
    .gnt     (gnt),
    .gnt_any (gnt_any)
  );

  // Next state and handshake outputs; ready is held low while reset is applied
  always_comb begin
    state_d   = state_q;
    In0_ready = 1'b0;
    In1_ready = 1'b0;
    S_valid   = 1'b0;
    Out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any && !RESET) begin
          accept    = 1'b1;
          In0_ready = (gnt == SEL_IN0);
          In1_ready = (gnt == SEL_IN1);
          state_d   = SEND_S;
        end
      end
      SEND_S: begin
        S_valid = 1'b1;
        if (S_ready) state_d = SEND_D;
      end
      SEND_D: begin
        Out_valid = 1'b1;
        if (Out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      data_q  <= '0;
      src_q   <= SEL_IN0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= (gnt == SEL_IN1) ? In1_data : In0_data;
        src_q  <= gnt;
      end
    end
  end

  assign S_data   = src_q;
  assign Out_data = data_q;

endmodule

// File: tb/tb_merge2_leaf.sv
// Directed bench for merge2_leaf; inputs change and outputs are sampled around the falling edge.
module tb_merge2_leaf;

  logic       CLK;
  logic       RESET;
  logic [8:0] In0_data, In1_data, Out_data;
  logic       In0_valid, In0_ready, In1_valid, In1_ready;
  logic       S_data, S_valid, S_ready, Out_valid, Out_ready;

  int compared   = 0;
  int mismatched = 0;

  merge2_leaf dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .In0_data  (In0_data),
    .In0_valid (In0_valid),
    .In0_ready (In0_ready),
    .In1_data  (In1_data),
    .In1_valid (In1_valid),
    .In1_ready (In1_ready),
    .S_data    (S_data),
    .S_valid   (S_valid),
    .S_ready   (S_ready),
    .Out_data  (Out_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       e;
    logic [8:0] ed;

    RESET = 1'b1;
    In0_data = '0; In0_valid = 1'b0; In1_data = '0; In1_valid = 1'b0;
    S_ready = 1'b0; Out_ready = 1'b0;

    // Reset state, and no acceptance while reset is held
    @(negedge CLK); @(negedge CLK);
    In0_valid = 1'b1; In0_data = 9'h1A5; #1;
    chk("rst_in0_ready", 9'(In0_ready), 9'h0);
    chk("rst_s_valid", 9'(S_valid), 9'h0);
    chk("rst_out_valid", 9'(Out_valid), 9'h0);
    chk("rst_out_data", Out_data, 9'h000);
    chk("rst_s_data", 9'(S_data), 9'h0);

    // Single packet from In0
    @(negedge CLK); RESET = 1'b0; S_ready = 1'b1; Out_ready = 1'b1; #1;
    chk("t1_in0_ready", 9'(In0_ready), 9'h1);
    chk("t1_in1_ready", 9'(In1_ready), 9'h0);
    @(negedge CLK); In0_valid = 1'b0; #1;
    chk("t1_s_valid", 9'(S_valid), 9'h1);
    chk("t1_s_data", 9'(S_data), 9'h0);
    chk("t1_out_valid_early", 9'(Out_valid), 9'h0);
    chk("t1_in0_ready_busy", 9'(In0_ready), 9'h0);
    @(negedge CLK); #1;
    chk("t1_out_valid", 9'(Out_valid), 9'h1);
    chk("t1_out_data", Out_data, 9'h1A5);
    chk("t1_s_valid_off", 9'(S_valid), 9'h0);
    chk("t1_in1_ready", 9'(In1_ready), 9'h0);
    @(negedge CLK); #1;
    chk("t1_idle_out_valid", 9'(Out_valid), 9'h0);

    // Both inputs contending continuously, from a fresh reset
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    In0_valid = 1'b1; In0_data = 9'h0F0; In1_valid = 1'b1; In1_data = 9'h10F; #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      e = 1'(k % 2);
`else
      e = 1'b0;
`endif
      ed = e ? 9'h10F : 9'h0F0;
      chk("t2_in0_ready", 9'(In0_ready), 9'(!e));
      chk("t2_in1_ready", 9'(In1_ready), 9'(e));
      @(negedge CLK); #1;
      chk("t2_s_valid", 9'(S_valid), 9'h1);
      chk("t2_s_data", 9'(S_data), 9'(e));
      @(negedge CLK); #1;
      chk("t2_out_valid", 9'(Out_valid), 9'h1);
      chk("t2_out_data", Out_data, ed);
      if (k == 3) begin
        In0_valid = 1'b0; In1_valid = 1'b0;
      end else begin
        @(negedge CLK); #1;
      end
    end

    // S back-pressure on an In1 packet
    @(negedge CLK); In1_valid = 1'b1; In1_data = 9'h155; S_ready = 1'b0; #1;
    chk("t3_in1_ready", 9'(In1_ready), 9'h1);
    chk("t3_in0_ready", 9'(In0_ready), 9'h0);
    @(negedge CLK); In1_valid = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_s_hold", 9'(S_valid), 9'h1);
      chk("t3_out_idle", 9'(Out_valid), 9'h0);
      @(negedge CLK); #1;
    end
    S_ready = 1'b1;
    chk("t3_s_valid", 9'(S_valid), 9'h1);
    chk("t3_s_data", 9'(S_data), 9'h1);
    @(negedge CLK); #1;
    chk("t3_out_valid", 9'(Out_valid), 9'h1);
    chk("t3_out_data", Out_data, 9'h155);

    // Out back-pressure with In0 already offering the next packet
    @(negedge CLK); In0_valid = 1'b1; In0_data = 9'h0AA; Out_ready = 1'b0; #1;
    chk("t4_in0_ready", 9'(In0_ready), 9'h1);
    @(negedge CLK); In0_data = 9'h0BB; #1;
    chk("t4_s_valid", 9'(S_valid), 9'h1);
    chk("t4_in0_ready_s", 9'(In0_ready), 9'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      chk("t4_out_hold", 9'(Out_valid), 9'h1);
      chk("t4_out_data_hold", Out_data, 9'h0AA);
      chk("t4_in0_ready_stall", 9'(In0_ready), 9'h0);
    end
    @(negedge CLK); Out_ready = 1'b1; #1;
    chk("t4_out_data", Out_data, 9'h0AA);
    chk("t4_s_valid_off", 9'(S_valid), 9'h0);
    @(negedge CLK); #1;
    chk("t4_in0_ready_next", 9'(In0_ready), 9'h1);
    @(negedge CLK); In0_valid = 1'b0; #1;
    chk("t4_s_data_next", 9'(S_data), 9'h0);
    @(negedge CLK); #1;
    chk("t4_out_valid_next", 9'(Out_valid), 9'h1);
    chk("t4_out_data_next", Out_data, 9'h0BB);

    // Reset while holding a packet in SEND_D
    @(negedge CLK); In0_valid = 1'b1; In0_data = 9'h1FF; #1;
    chk("t5_in0_ready", 9'(In0_ready), 9'h1);
    @(negedge CLK); In0_valid = 1'b0; Out_ready = 1'b0; #1;
    chk("t5_s_valid", 9'(S_valid), 9'h1);
    @(negedge CLK); #1;
    chk("t5_out_valid", 9'(Out_valid), 9'h1);
    chk("t5_out_data", Out_data, 9'h1FF);
    RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0; Out_ready = 1'b1; #1;
    chk("t5_rst_out_valid", 9'(Out_valid), 9'h0);
    chk("t5_rst_s_valid", 9'(S_valid), 9'h0);
    chk("t5_rst_out_data", Out_data, 9'h000);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      chk("t5_no_out", 9'(Out_valid), 9'h0);
      chk("t5_no_s", 9'(S_valid), 9'h0);
    end
    @(negedge CLK); In0_valid = 1'b1; In0_data = 9'h003; #1;
    chk("t5_in0_ready_new", 9'(In0_ready), 9'h1);
    @(negedge CLK); In0_valid = 1'b0; #1;
    chk("t5_s_valid_new", 9'(S_valid), 9'h1);
    chk("t5_s_data_new", 9'(S_data), 9'h0);
    @(negedge CLK); #1;
    chk("t5_out_valid_new", 9'(Out_valid), 9'h1);
    chk("t5_out_data_new", Out_data, 9'h003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/merge2_leaf.md
Name: merge2_leaf

Overview:
- Upstream-direction counterpart of the leaf decoder in the NoC tree.
- Merges two downstream 9-bit packet channels (In0, In1) into one upstream channel (Out).
- Emits a 1-bit source-select token on S before each packet, mirroring the decoder's S-then-data ordering. S = 0 means the packet came from In0; S = 1 means it came from In1.
- Arbitration between simultaneous requesters is round-robin or fixed-priority, chosen by a build macro.

Parameters:
- W, 9, packet width in bits; address field is [W-1:W-4].
- INIT_PRIO, 0, input favoured first after reset (0 = In0, 1 = In1).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- In0_data  input  W  packet from child 0.
- In0_valid  input  1  child 0 offers a packet.
- In0_ready  output  1  In0 packet accepted this cycle (when valid).
- In1_data  input  W  packet from child 1.
- In1_valid  input  1  child 1 offers a packet.
- In1_ready  output  1  In1 packet accepted this cycle (when valid).
- S_data  output  1  source of the held packet (0 = In0, 1 = In1).
- S_valid  output  1  S token offered.
- S_ready  input  1  S token consumed.
- Out_data  output  W  merged packet to parent.
- Out_valid  output  1  packet offered.
- Out_ready  input  1  packet consumed.

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-high on RESET.
- Reset values: state = IDLE; data register = 0; src = 0; prio = INIT_PRIO; all valid and ready outputs = 0.
- Handshake rule: a transfer happens on any cycle where valid and ready are both 1 at the rising edge.
  - Once asserted, a valid output and its data hold stable until the transfer.
- State machine, three states:
  - IDLE
    - In0_ready / In1_ready are driven combinationally, only to the granted input. The other input sees ready = 0.
    - Grant rule: if only one input is valid, grant it. If both are valid, grant the input selected by prio.
    - On the accepted transfer: capture data and src; go to SEND_S.
  - SEND_S
    - S_valid = 1; S_data = src.
    - On S handshake: go to SEND_D.
  - SEND_D
    - Out_valid = 1; Out_data = the captured packet.
    - On Out handshake: go to IDLE.
- Prio update: after each Out handshake, prio = ~src (round-robin mode only).
- Minimum latency and throughput:
  - Input accepted at edge T; S_valid is high at T+1; Out_valid is high at T+2 at the earliest.
  - At most one packet every 3 cycles.
- Data integrity: packet bits pass through unmodified. No address checking or rewriting.
- Boundary conditions:
  - Back-pressure: S_ready or Out_ready held low stalls the FSM indefinitely with outputs stable. Neither input is accepted while stalled.
  - No overlap: S_valid and Out_valid are never high in the same cycle. In*_ready is 0 outside IDLE.
  - Valid drop by a sender before acceptance is a protocol violation. The block does not need to handle it, but must not deadlock: it re-arbitrates in IDLE.
  - RESET asserted mid-operation: any held packet is discarded; the block returns to reset values on the next edge. Neither S nor Out is sent for the discarded packet.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration; prio toggles to the loser after every completed Out handshake. This guarantees each contender waits at most one packet.
- Undefined: fixed priority.
  - INIT_PRIO always wins a tie; the prio register and its update logic are removed.
  - Starvation of the other input is permitted.

Decomposition:
- Shared noc package:
  - localparams PKT_W = 9, ADDR_HI = 8, ADDR_LO = 5, and the S encodings SEL_IN0 = 0, SEL_IN1 = 1 (shared with the decoder).
  - The state enum typedef {IDLE, SEND_S, SEND_D}.
- Natural sub-module: arb2_rr, a combinational grant from (v0, v1, prio) plus the prio register under ARB_RR_EN. The FSM and datapath stay in merge2_leaf.

Test Plan:
- Reset, then only In0 offers 9'h1A5 with S_ready = Out_ready = 1:
  - In0_ready pulses 1 cycle; S = 0 at T+1; Out = 9'h1A5 at T+2.
  - In1_ready stays 0 throughout.
- Both inputs valid continuously (In0 = 9'h0F0, In1 = 9'h10F), ARB_RR_EN defined, INIT_PRIO = 0:
  - Outputs alternate 0F0 (S = 0), 10F (S = 1), 0F0, ...
  - Without ARB_RR_EN: only 0F0 appears, repeated, with S = 0 each time.
- In1 offers 9'h155 with S_ready low for 5 cycles:
  - S_valid is held for those cycles; Out_valid stays 0.
  - After S_ready rises: S = 1, then Out = 9'h155.
- Out_ready low for 4 cycles while In0 keeps offering a new packet:
  - Out_data is stable through the stall; In0_ready stays 0.
  - The new packet is accepted only after the Out handshake.
- RESET pulsed while in SEND_D holding 9'h1FF:
  - Next cycle Out_valid = 0 and state = IDLE.
  - 1FF is never delivered; the next In0 packet, 9'h003, flows normally.
